// File: rtl/operand_demux8.sv
// ============================================================================
// Module   : operand_demux8
// Brief    : Byte-wide 1-to-2 operand demultiplexer; steers tagged bytes into
//            A/B holding registers and hands off complete pairs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_demux8 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_s,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_a,
    output logic [7:0] out_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       ovw,
    output logic [7:0] pair_cnt
);

    localparam logic [1:0] c_EMPTY  = 2'd0;
    localparam logic [1:0] c_HAVE_A = 2'd1;
    localparam logic [1:0] c_HAVE_B = 2'd2;
    localparam logic [1:0] c_FULL   = 2'd3;

    logic [1:0] r_state;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_out_valid;
    logic       r_ovw;
    logic [7:0] r_pair_cnt;

    logic       w_accept;
    logic       w_handoff;
    logic [1:0] w_state_nxt;
    logic       w_ovw_nxt;

    // Ready depends only on registered state so the source sees no comb path.
    assign in_ready  = (r_state != c_FULL);
    assign w_accept  = in_valid && in_ready;
    assign w_handoff = r_out_valid && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_ovw_nxt   = 1'b0;
        case (r_state)
            c_EMPTY: begin
                if (w_accept)
                    w_state_nxt = in_s ? c_HAVE_A : c_HAVE_B;
            end
            c_HAVE_A: begin
                if (w_accept) begin
                    if (in_s) w_ovw_nxt   = 1'b1;
                    else      w_state_nxt = c_FULL;
                end
            end
            c_HAVE_B: begin
                if (w_accept) begin
                    if (!in_s) w_ovw_nxt   = 1'b1;
                    else       w_state_nxt = c_FULL;
                end
            end
            c_FULL: begin
                if (w_handoff)
                    w_state_nxt = c_EMPTY;
            end
            default: w_state_nxt = c_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_EMPTY;
            r_a         <= 8'h00;
            r_b         <= 8'h00;
            r_out_valid <= 1'b0;
            r_ovw       <= 1'b0;
            r_pair_cnt  <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt == c_FULL);
            r_ovw       <= w_ovw_nxt;
            if (w_accept && in_s)
                r_a <= in_data;
            if (w_accept && !in_s)
                r_b <= in_data;
            if (w_handoff)
                r_pair_cnt <= r_pair_cnt + 8'd1;
        end
    end

    assign out_a     = r_a;
    assign out_b     = r_b;
    assign out_valid = r_out_valid;
    assign ovw       = r_ovw;
    assign pair_cnt  = r_pair_cnt;

endmodule

`default_nettype wire
